// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RV32I funct3 encodings for loads and stores
//   - FSM state enum and access-size enum
//   - byte-lane count of a memory word
//   - size decode and legality helpers used by the top level
package lsu_pkg;

    localparam int unsigned LANES = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRmwRead,
        StWrite,
        StResp
    } lsu_state_t;

    typedef enum logic [1:0] {
        SzByte,
        SzHalf,
        SzWord
    } lsu_size_t;

    // Any encoding that is not a recognised sub-word access falls back to a word access.
    function automatic lsu_size_t size_of(input logic write, input logic [2:0] funct3);
        lsu_size_t size;
        case (funct3)
            F3_B:    size = SzByte;
            F3_H:    size = SzHalf;
            F3_BU:   size = write ? SzWord : SzByte;
            F3_HU:   size = write ? SzWord : SzHalf;
            default: size = SzWord;
        endcase
        return size;
    endfunction

    function automatic logic is_illegal(input logic       write,
                                        input logic [2:0] funct3,
                                        input logic [1:0] offset);
        logic bad_f3;
        logic misaligned;
        if (write) begin
            bad_f3 = funct3[2] || (funct3 == 3'b011);
        end else begin
            bad_f3 = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
        end
        case (size_of(write, funct3))
            SzHalf:  misaligned = offset[0];
            SzWord:  misaligned = (offset != 2'b00);
            default: misaligned = 1'b0;
        endcase
        return bad_f3 || misaligned;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response and memory-side signals of the load/store unit.
//   master modport: core + memory side (drives requests and memory read data)
//   slave modport : the load/store unit
//   req_*  : request handshake (valid/ready, write, funct3, addr, wdata)
//   rsp_*  : one-cycle response pulse with load data and error flag
//   mem_*  : word-addressed memory port (write enable, addr, wdata, combinational rdata)
interface load_store_unit_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [2:0]            req_funct3;
    logic [DATA_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_error;
    logic                  mem_write;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error, mem_write, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_error, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for the load/store unit (little-endian).
//   word_i     : word read from memory
//   wdata_i    : store data (low byte/halfword used for SB/SH)
//   offset_i   : byte offset addr[1:0]
//   size_i     : access size
//   unsigned_i : zero-extend instead of sign-extend for sub-word loads
//   load_o     : extracted and extended load result
//   merge_o    : word_i with the addressed lane(s) replaced by store data
module lsu_align
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] word_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [1:0]            offset_i,
    input  lsu_size_t             size_i,
    input  logic                  unsigned_i,
    output logic [DATA_WIDTH-1:0] load_o,
    output logic [DATA_WIDTH-1:0] merge_o
);

    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [LANES-1:0] lane_we;
    logic [7:0]       lane_src [LANES];

    always_comb begin
        ld_byte = '0;
        for (int i = 0; i < LANES; i++) begin
            if (offset_i == 2'(i)) ld_byte = word_i[8*i +: 8];
        end
        // Halfword lane comes from addr[1] only, so an odd address selects its aligned half.
        ld_half = offset_i[1] ? word_i[31:16] : word_i[15:0];
        case (size_i)
            SzByte:  load_o = {{(DATA_WIDTH-8){ld_byte[7] & ~unsigned_i}}, ld_byte};
            SzHalf:  load_o = {{(DATA_WIDTH-16){ld_half[15] & ~unsigned_i}}, ld_half};
            default: load_o = word_i;
        endcase
    end

    always_comb begin
        lane_we = '0;
        merge_o = word_i;
        for (int i = 0; i < LANES; i++) begin
            lane_src[i] = wdata_i[8*i +: 8];
            case (size_i)
                SzByte: begin
                    lane_we[i]  = (offset_i == 2'(i));
                    lane_src[i] = wdata_i[7:0];
                end
                SzHalf: begin
                    lane_we[i]  = (offset_i[1] == (i >= 2));
                    lane_src[i] = wdata_i[8*(i%2) +: 8];
                end
                default: lane_we[i] = 1'b1;
            endcase
            if (lane_we[i]) merge_o[8*i +: 8] = lane_src[i];
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding RV32I load/store unit in front of a word-addressed memory.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : load_store_unit_if.slave (request handshake, response pulse, memory port)
// Sub-word stores are read-modify-write: the memory word is read, merged, then written whole.
// Build option LSU_MISALIGN_CHECK_EN: when defined, misaligned or illegal-funct3 requests are
// answered with rsp_error and no memory access; when undefined, rsp_error stays 0, halfword
// and word accesses ignore the low address bits and unknown funct3 acts as a word access.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input logic              clk,
    input logic              rst,
    load_store_unit_if.slave bus
);

    lsu_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] merge_q, merge_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [2:0]            funct3_q, funct3_d;
    logic                  write_q, write_d;
    logic                  error_q, error_d;

    lsu_size_t             req_size;
    lsu_size_t             cur_size;
    logic                  req_illegal;
    logic [DATA_WIDTH-1:0] ld_ext;
    logic [DATA_WIDTH-1:0] st_merged;

    assign req_size = size_of(bus.req_write, bus.req_funct3);
    assign cur_size = size_of(write_q, funct3_q);

`ifdef LSU_MISALIGN_CHECK_EN
    assign req_illegal = is_illegal(bus.req_write, bus.req_funct3, bus.req_addr[1:0]);
`else
    // error_q can then never be set, which ties rsp_error low.
    assign req_illegal = 1'b0;
`endif

    lsu_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_align (
        .word_i    (bus.mem_rdata),
        .wdata_i   (wdata_q),
        .offset_i  (addr_q[1:0]),
        .size_i    (cur_size),
        .unsigned_i(funct3_q[2]),
        .load_o    (ld_ext),
        .merge_o   (st_merged)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        merge_d  = merge_q;
        rdata_d  = rdata_q;
        funct3_d = funct3_q;
        write_d  = write_q;
        error_d  = error_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    funct3_d = bus.req_funct3;
                    write_d  = bus.req_write;
                    // Word stores write the request data straight from the merge register.
                    merge_d  = bus.req_wdata;
                    error_d  = req_illegal;
                    if (req_illegal) begin
                        state_d = StResp;
                    end else if (!bus.req_write) begin
                        state_d = StLoad;
                    end else if (req_size == SzWord) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRmwRead;
                    end
                end
            end
            StLoad: begin
                rdata_d = ld_ext;
                state_d = StResp;
            end
            StRmwRead: begin
                merge_d = st_merged;
                state_d = StWrite;
            end
            StWrite: state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            wdata_q  <= '0;
            merge_q  <= '0;
            rdata_q  <= '0;
            funct3_q <= '0;
            write_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            merge_q  <= merge_d;
            rdata_q  <= rdata_d;
            funct3_q <= funct3_d;
            write_q  <= write_d;
            error_q  <= error_d;
        end
    end

    assign bus.req_ready = (state_q == StIdle);
    assign bus.rsp_valid = (state_q == StResp);
    assign bus.rsp_error = (state_q == StResp) && error_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.mem_write = (state_q == StWrite);
    assign bus.mem_addr  = {addr_q[DATA_WIDTH-1:2], 2'b00};
    assign bus.mem_wdata = merge_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized bench for load_store_unit with a request-level
// reference model and a per-cycle compare process.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic clk;
    logic rst;

    load_store_unit_if #(.DATA_WIDTH(32)) bus ();

    load_store_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] img(input int i);
        logic [31:0] k;
        k = 32'(i + 1);
        return (i == 4) ? 32'h8081F2F3 : ((32'h9E3779B9 * k) ^ 32'h5A5A0000);
    endfunction

    // Memory seen by the DUT.
    logic [31:0] env_mem [16];
    assign bus.mem_rdata = env_mem[bus.mem_addr[5:2]];

    initial begin
        for (int i = 0; i < 16; i++) env_mem[i] = img(i);
        forever begin
            @(posedge clk);
            if (bus.mem_write) env_mem[bus.mem_addr[5:2]] <= bus.mem_wdata;
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] rdata;
        logic [31:0] wword;
        bit          err;
        bit          load;
        int          lat;
        int          wcyc;
    } exp_t;

    function automatic exp_t predict(input bit w, input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] wd, input logic [31:0] word);
        exp_t        e;
        bit          legal;
        int          nb;
        int          off;
        int          sh;
        logic [31:0] mask;
        legal = w ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
        nb    = legal ? (1 << f3[1:0]) : 4;
        off   = int'(a[1:0]);
        e.err = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        e.err = !legal || ((off % nb) != 0);
`endif
        sh      = 8 * (off - (off % nb));
        mask    = (nb == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * nb)) - 32'd1);
        e.load  = !w;
        e.rdata = (word >> sh) & mask;
        if (!w && !f3[2] && nb < 4 && e.rdata[8*nb-1]) e.rdata = e.rdata | ~mask;
        e.wword = (word & ~(mask << sh)) | ((wd & mask) << sh);
        e.lat   = e.err ? 1 : ((!w || nb == 4) ? 2 : 3);
        e.wcyc  = (e.err || !w) ? 0 : ((nb == 4) ? 1 : 2);
        return e;
    endfunction

    logic [31:0] ref_mem [16];
    bit          m_act, m_err, m_load;
    int          m_cyc, m_lat, m_wcyc;
    logic [31:0] m_rdata, m_pend, m_addr, m_wword;

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = img(i);
        m_act = 0; m_err = 0; m_load = 0; m_cyc = 0; m_lat = 0; m_wcyc = 0;
        m_rdata = '0; m_pend = '0; m_addr = '0; m_wword = '0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_act   <= 0;
                m_rdata <= '0;
                m_addr  <= '0;
            end else if (m_act) begin
                if (m_wcyc == m_cyc) ref_mem[m_addr[5:2]] <= m_wword;
                if (m_cyc + 1 == m_lat && m_load && !m_err) m_rdata <= m_pend;
                if (m_cyc == m_lat) m_act <= 0;
                else m_cyc <= m_cyc + 1;
            end else if (bus.req_valid) begin
                exp_t e;
                e = predict(bus.req_write, bus.req_funct3, bus.req_addr, bus.req_wdata,
                            ref_mem[bus.req_addr[5:2]]);
                m_act  <= 1;
                m_cyc  <= 1;
                m_lat  <= e.lat;
                m_wcyc <= e.wcyc;
                m_err  <= e.err;
                m_load <= e.load;
                m_pend <= e.rdata;
                m_wword <= e.wword;
                m_addr <= bus.req_addr;
            end
        end
    end

    // ---------------- literal expectations posted by the driver ----------------
    string       pin_name [64];
    logic [31:0] pin_got  [64];
    logic [31:0] pin_exp  [64];
    int          pin_wr = 0;

    task automatic pin(input string n, input logic [31:0] g, input logic [31:0] e);
        if (pin_wr < 64) begin
            pin_name[pin_wr] = n;
            pin_got[pin_wr]  = g;
            pin_exp[pin_wr]  = e;
            pin_wr++;
        end
    endtask

    // ---------------- compare process ----------------
    int unsigned n_cmp;
    int unsigned n_fail;
    int          pin_rd;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", n, got, want, $time);
        end
    endtask

    initial begin
        bit exp_v;
        bit exp_w;
        n_cmp  = 0;
        n_fail = 0;
        pin_rd = 0;
        forever begin
            @(negedge clk);
            exp_v = m_act && (m_cyc == m_lat);
            exp_w = m_act && (m_cyc == m_wcyc);
            chk("req_ready", 32'(bus.req_ready), 32'(!m_act));
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_v));
            if (exp_v) chk("rsp_error", 32'(bus.rsp_error), 32'(m_err));
            chk("rsp_rdata", bus.rsp_rdata, m_rdata);
            chk("mem_write", 32'(bus.mem_write), 32'(exp_w));
            if (exp_w) chk("mem_wdata", bus.mem_wdata, m_wword);
            chk("mem_addr", bus.mem_addr, {m_addr[31:2], 2'b00});
            while (pin_rd < pin_wr) begin
                chk(pin_name[pin_rd], pin_got[pin_rd], pin_exp[pin_rd]);
                pin_rd++;
            end
        end
    end

    // ---------------- driver ----------------
    logic [31:0] rd, wa;
    bit          er, rb;
    int          lat, wc, wn, nv;

    task automatic do_req(input bit w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd);
        int waitc;
        waitc = 0;
        @(negedge clk);
        while (!bus.req_ready && waitc < 10) begin
            @(negedge clk);
            waitc++;
        end
        if (waitc >= 10) pin("ready_timeout", 32'(waitc), 32'd9);
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        rd = '0; wa = '0; er = 0; rb = 0; lat = 0; wc = 0; wn = 0;
        for (int k = 1; k <= 6 && lat == 0; k++) begin
            @(negedge clk);
            if (bus.mem_write) begin
                wc = k;
                wn++;
                wa = bus.mem_addr;
            end
            if (bus.req_ready) rb = 1;
            if (bus.rsp_valid) begin
                lat = k;
                rd  = bus.rsp_rdata;
                er  = bus.rsp_error;
            end
        end
        if (lat == 0) pin("rsp_timeout", 32'(lat), 32'd1);
    endtask

    initial begin
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        repeat (3) @(negedge clk);
        pin("rst_ready", 32'(bus.req_ready), 32'd1);
        pin("rst_mem_write", 32'(bus.mem_write), 32'd0);
        pin("rst_rdata", bus.rsp_rdata, 32'd0);
        rst = 1'b0;

        do_req(1'b0, F3_B, 32'h13, 32'h0);
        pin("lb_data", rd, 32'hFFFFFF80);
        pin("lb_lat", 32'(lat), 32'd2);
        pin("lb_err", 32'(er), 32'd0);

        do_req(1'b0, F3_BU, 32'h13, 32'h0);
        pin("lbu_data", rd, 32'h00000080);

        do_req(1'b0, F3_H, 32'h12, 32'h0);
        pin("lh_data", rd, 32'hFFFF8081);
        pin("lh_nowrite", 32'(wn), 32'd0);

        do_req(1'b0, F3_HU, 32'h10, 32'h0);
        pin("lhu_data", rd, 32'h0000F2F3);

        do_req(1'b0, F3_W, 32'h12, 32'h0);
`ifdef LSU_MISALIGN_CHECK_EN
        pin("lw_mis_lat", 32'(lat), 32'd1);
        pin("lw_mis_err", 32'(er), 32'd1);
        pin("lw_mis_data_kept", rd, 32'h0000F2F3);
`else
        pin("lw_mis_lat", 32'(lat), 32'd2);
        pin("lw_mis_err", 32'(er), 32'd0);
        pin("lw_mis_data", rd, 32'h8081F2F3);
`endif
        pin("lw_mis_nowrite", 32'(wn), 32'd0);

        // SH aborted by an asynchronous reset while reading the old word.
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_funct3 = F3_H;
        bus.req_addr   = 32'h12;
        bus.req_wdata  = 32'h0000BEEF;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        #2;
        rst = 1'b1;
        wn = 0;
        nv = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.mem_write) wn++;
            if (bus.rsp_valid) nv++;
        end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.mem_write) wn++;
            if (bus.rsp_valid) nv++;
        end
        pin("rst_mid_write", 32'(wn), 32'd0);
        pin("rst_mid_rsp", 32'(nv), 32'd0);
        pin("rst_mid_ready", 32'(bus.req_ready), 32'd1);
        pin("rst_mid_word", env_mem[4], 32'h8081F2F3);

        do_req(1'b1, F3_B, 32'h11, 32'h123456AA);
        pin("sb_wcyc", 32'(wc), 32'd2);
        pin("sb_wcount", 32'(wn), 32'd1);
        pin("sb_waddr", wa, 32'h10);
        pin("sb_lat", 32'(lat), 32'd3);
        pin("sb_rdata_kept", rd, 32'h0);
        @(negedge clk);
        pin("sb_word", env_mem[4], 32'h8081AAF3);

        do_req(1'b1, F3_W, 32'h14, 32'hDEADBEEF);
        pin("sw_wcyc", 32'(wc), 32'd1);
        pin("sw_lat", 32'(lat), 32'd2);
        pin("sw_ready_busy", 32'(rb), 32'd0);
        do_req(1'b0, F3_W, 32'h14, 32'h0);
        pin("lw_after_sw", rd, 32'hDEADBEEF);

        for (int n = 0; n < 300; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   32'($urandom_range(0, 63)), $urandom);
        end

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
